// File: rtl/mem_array_pkg.sv
// Shared types and default sizing for the mem_array word store and its controller.
package mem_array_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/mem_array_ctrl.sv
// Clear-sweep controller for mem_array: owns the CLEAR/IDLE FSM, the sweep
// address counter and the registered rdy/cdone outputs.
module mem_array_ctrl
  import mem_array_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          rdy,
  output logic          cdone,
  output logic          sweep,
  output logic [AW-1:0] sweep_addr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      sweep_addr <= '0;
      rdy        <= 1'b0;
      cdone      <= 1'b0;
    end else begin
      cdone <= 1'b0;
      case (state)
        CLEAR: begin
          // clr is deliberately not looked at here: a running sweep is never restarted
          if (sweep_addr == LAST) begin
            state      <= IDLE;
            sweep_addr <= '0;
            rdy        <= 1'b1;
            cdone      <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + AW'(1);
          end
        end
        IDLE: begin
          if (clr) begin
            state      <= CLEAR;
            sweep_addr <= '0;
            rdy        <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign sweep = (state == CLEAR);

endmodule

// File: rtl/mem_array.sv
// Single-port word store with a one-word-per-cycle clear sweep and gated read data.
// Define MEM_ARRAY_OUTREG_EN to add an output register stage (read latency 2).
module mem_array
  import mem_array_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             rw,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] inp,
  input  logic             clr,
  output logic             rdy,
  output logic [WIDTH-1:0] outp,
  output logic             outv,
  output logic             cdone
);

  localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

  logic             sweep;
  logic [AW-1:0]    sweep_addr;
  logic             in_range;
  logic             acc;
  logic [WIDTH-1:0] mem [DEPTH];

  mem_array_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .rdy        (rdy),
    .cdone      (cdone),
    .sweep      (sweep),
    .sweep_addr (sweep_addr)
  );

  // Non-power-of-two depths leave unused address codes; those act as a zero word.
  assign in_range = ({1'b0, addr} < DEPTH_V);
  assign acc      = sel & rdy & ~clr;

  always_ff @(posedge clk) begin
    if (sweep) begin
      mem[sweep_addr] <= '0;
    end else if (acc && rw && in_range) begin
      mem[addr] <= inp;
    end
  end

  // Stage p0: word captured at acceptance
  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p0 <= 1'b0;
    else        vld_p0 <= acc & ~rw;
  end

  always_ff @(posedge clk) begin
    if (acc && !rw) data_p0 <= in_range ? mem[addr] : '0;
  end

`ifdef MEM_ARRAY_OUTREG_EN
  // Stage p1: optional output register
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    data_p1 <= data_p0;
  end

  assign outv = vld_p1;
  assign outp = vld_p1 ? data_p1 : '0;
`else
  assign outv = vld_p0;
  assign outp = vld_p0 ? data_p0 : '0;
`endif

endmodule

// File: tb/tb_mem_array.sv
// Bench for mem_array: DEPTH=8 and DEPTH=6 instances share one stimulus stream,
// checked every cycle against a behavioural model plus literal expectations.
module tb_mem_array;

`ifdef MEM_ARRAY_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk, rst_n, sel, rw, clr;
  logic [2:0] addr;
  logic [7:0] inp;
  logic       rdy8, outv8, cdone8, rdy6, outv6, cdone6;
  logic [7:0] outp8, outp6;

  int checks = 0;
  int failures = 0;

  mem_array #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .inp(inp),
    .clr(clr), .rdy(rdy8), .outp(outp8), .outv(outv8), .cdone(cdone8)
  );

  mem_array #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rw(rw), .addr(addr), .inp(inp),
    .clr(clr), .rdy(rdy6), .outp(outp6), .outv(outv6), .cdone(cdone6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sweep is just "busy for DEPTH cycles, then everything is zero".
  int         dep [2] = '{8, 6};
  int         clear_left [2] = '{8, 6};
  logic [7:0] m_mem [2][8];
  logic       m_rdy [2], m_cdone [2], m_v0 [2], m_v1 [2];
  logic [7:0] m_d0 [2], m_d1 [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = 0; m_cdone[k] = 0; m_v0[k] = 0; m_v1[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
      for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        clear_left[k] = dep[k];
        m_rdy[k] = 0; m_cdone[k] = 0;
        m_v0[k] = 0; m_v1[k] = 0; m_d0[k] = 0; m_d1[k] = 0;
      end else begin
        m_v1[k] = m_v0[k]; m_d1[k] = m_d0[k];
        m_v0[k] = 0; m_d0[k] = 0; m_cdone[k] = 0;
        if (clear_left[k] > 0) begin
          clear_left[k]--;
          if (clear_left[k] == 0) begin
            m_cdone[k] = 1;
            for (int i = 0; i < 8; i++) m_mem[k][i] = 8'h00;
          end
        end else if (clr) begin
          clear_left[k] = dep[k];
        end else if (sel) begin
          if (rw) begin
            if (int'(addr) < dep[k]) m_mem[k][addr] = inp;
          end else begin
            m_v0[k] = 1;
            m_d0[k] = (int'(addr) < dep[k]) ? m_mem[k][addr] : 8'h00;
          end
        end
        m_rdy[k] = (clear_left[k] == 0);
      end
    end
  end

  function automatic logic exp_v(input int k);
    return (LAT == 1) ? m_v0[k] : m_v1[k];
  endfunction

  function automatic logic [7:0] exp_d(input int k);
    return (LAT == 1) ? m_d0[k] : m_d1[k];
  endfunction

  always @(posedge clk) begin
    #1;
    chk("model_rdy8", rdy8, m_rdy[0]);
    chk("model_cdone8", cdone8, m_cdone[0]);
    chk("model_outv8", outv8, exp_v(0));
    chk("model_outp8", outp8, exp_d(0));
    chk("model_rdy6", rdy6, m_rdy[1]);
    chk("model_cdone6", cdone6, m_cdone[1]);
    chk("model_outv6", outv6, exp_v(1));
    chk("model_outp6", outp6, exp_d(1));
  end

  // Counts rising edges until the DEPTH=8 instance raises rdy (bounded).
  task automatic sweep_len(output int n8, output int n6, output logic cd8);
    n8 = 0; n6 = 0; cd8 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy6 && n6 == 0) n6 = i;
      if (rdy8) begin
        n8 = i; cd8 = cdone8;
        break;
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); sel = 1; rw = 1; addr = a; inp = d; clr = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic v8, output logic [7:0] d8,
                    output logic v6, output logic [7:0] d6);
    @(negedge clk); sel = 1; rw = 0; addr = a; clr = 0;
    @(negedge clk); sel = 0;
    repeat (LAT - 1) @(negedge clk);
    v8 = outv8; d8 = outp8; v6 = outv6; d6 = outp6;
  endtask

  int         n8, n6;
  logic       cd8, v8, v6;
  logic [7:0] d8, d6;

  initial begin
    rst_n = 0; sel = 0; rw = 0; addr = 0; inp = 0; clr = 0;
    repeat (3) @(negedge clk);
    chk("reset_rdy8", rdy8, 0);
    chk("reset_outv8", outv8, 0);
    chk("reset_outp8", outp8, 0);
    chk("reset_cdone8", cdone8, 0);
    rst_n = 1;
    sweep_len(n8, n6, cd8);
    chk("init_sweep_len8", n8, 8);
    chk("init_sweep_len6", n6, 6);
    chk("init_cdone8", cd8, 1);

    rd(3'd5, v8, d8, v6, d6);
    chk("rd_after_init_v", v8, 1);
    chk("rd_after_init_d", d8, 8'h00);

    wr(3'd3, 8'hA5);
    rd(3'd3, v8, d8, v6, d6);
    chk("raw_a5_v8", v8, 1);
    chk("raw_a5_d8", d8, 8'hA5);
    chk("raw_a5_d6", d6, 8'hA5);
    @(negedge clk);
    chk("raw_a5_gap_outp", outp8, 8'h00);

    // clr and a read in the same cycle: the clear wins, the read vanishes
    @(negedge clk); clr = 1; sel = 1; rw = 0; addr = 3'd3;
    @(posedge clk); #1;
    clr = 0; sel = 0;
    chk("clr_blocks_read_outv", outv8, 0);
    chk("clr_drops_rdy", rdy8, 0);
    sweep_len(n8, n6, cd8);
    chk("clr_sweep_len8", n8, 8);
    chk("clr_sweep_len6", n6, 6);
    chk("clr_cdone8", cd8, 1);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v8, d8, v6, d6);
      chk($sformatf("post_clr_word%0d", i), d8, 8'h00);
    end

    for (int i = 0; i < 6; i++) wr(3'(i), 8'h10 + 8'(i));
    wr(3'd7, 8'hFF);
    rd(3'd7, v8, d8, v6, d6);
    chk("oob_v6", v6, 1);
    chk("oob_d6", d6, 8'h00);
    chk("inrange7_d8", d8, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), v8, d8, v6, d6);
      chk($sformatf("d6_word%0d", i), d6, 8'h10 + 8'(i));
    end

    wr(3'd0, 8'h3C);
    @(negedge clk); sel = 1; rw = 0; addr = 3'd0;
    @(negedge clk); sel = 0;
`ifdef MEM_ARRAY_OUTREG_EN
    chk("lat2_early_outv", outv8, 0);
    @(negedge clk);
`endif
    chk("lat_outv", outv8, 1);
    chk("lat_outp", outp8, 8'h3C);

    // Reset lands just after a read is accepted: no further outv, sweep restarts
    @(negedge clk); sel = 1; rw = 0; addr = 3'd2;
    @(posedge clk); #2;
    sel = 0; rst_n = 0;
    #1;
    chk("rst_drop_outv", outv8, 0);
    chk("rst_drop_outp", outp8, 8'h00);
    chk("rst_drop_rdy", rdy8, 0);
    repeat (2) @(negedge clk);
    chk("rst_hold_outv", outv8, 0);
    rst_n = 1;
    sweep_len(n8, n6, cd8);
    chk("rst_sweep_len8", n8, 8);
    chk("rst_sweep_len6", n6, 6);
    rd(3'd3, v8, d8, v6, d6);
    chk("rst_word3_zero", d8, 8'h00);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
